exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage in-order pipeline. It sits between the decode stage and `mem_stage` and uses the same valid/allow-in handshake. It computes the ALU result, runs a multi-cycle iterative 32-bit divider, and issues the data-SRAM request for loads and stores. It hands `{pc, alu_result, res_from_mem, reg_we, reg_waddr}` to the memory stage.

## Interface
- `ID_TO_EXE_BUS_WIDTH`, 152: width of the decode→execute bus. Defined in `mycpu_top.h`.
- `EXE_TO_MEM_BUS_WIDTH`, 71: width of the execute→memory bus, laid out as `{pc[31:0], alu_result[31:0], res_from_mem, reg_we, reg_waddr[4:0]}`.

Ports (clock and reset first):
- `clk` (in, 1): the single clock, rising edge.
- `reset` (in, 1): asynchronous, active-low. Asserted at 0.
- `exe_allow_in` (out, 1): stage can accept a new instruction.
- `id_to_exe_valid` (in, 1): decode stage offers an instruction.
- `mem_allow_in` (in, 1): memory stage can accept.
- `exe_to_mem_valid` (out, 1): this stage offers an instruction.
- `id_to_exe_bus` (in, 152): `{pc[31:0], alu_op[11:0], div_op[3:0], src1[31:0], src2[31:0], rkd_value[31:0], mem_we, res_from_mem, reg_we, reg_waddr[4:0]}`.
- `exe_to_mem_bus` (out, 71): bus to the memory stage, layout as above.
- `data_sram_en` (out, 1): data SRAM request enable.
- `data_sram_we` (out, 4): byte write enables.
- `data_sram_addr` (out, 32): data SRAM address.
- `data_sram_wdata` (out, 32): store data.

## Operation
Pipeline control:
- `exe_valid` is cleared by reset. It loads `id_to_exe_valid` when `exe_allow_in` is high.
- `exe_reg` loads `id_to_exe_bus` when `exe_allow_in && id_to_exe_valid`. It is not reset.
- `exe_allow_in = !exe_valid || (exe_ready_go && mem_allow_in)`.
- `exe_to_mem_valid = exe_valid && exe_ready_go`.
- `exe_ready_go` = 1 when `div_op == 0`; otherwise it equals (divider state == DONE).

ALU (`alu_op` one-hot, bit 0..11):
- Operations in order: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- Shifts use `src2[4:0]`. lui returns `src2`.
- Add and sub wrap modulo 2^32.
- If `alu_op` is all-zero, the result is 0.

Divider (`div_op` one-hot, bit 0..3: div.w, mod.w, div.wu, mod.wu):
- Radix-2 restoring divider on magnitudes (signed ops take absolute values).
- Signed fix-up: quotient sign = sign(src1) XOR sign(src2); remainder sign = sign(src1).
- Divide by zero: quotient 0xFFFFFFFF, remainder = `src1`, for both signed and unsigned ops.
- -2^31 / -1: quotient 0x80000000, remainder 0.
- FSM transitions:
  - IDLE→BUSY when `exe_valid && div_op != 0`. Operands are latched from `exe_reg`; the iteration counter is set to 0.
  - BUSY: one quotient bit per cycle. Moves to DONE after 32 iterations (counter reaches 31).
  - DONE: result is held. Returns to IDLE when `exe_ready_go && mem_allow_in`.
- In a divide, `alu_result` takes the quotient (div.*) or the remainder (mod.*) instead of the ALU output.

Memory request:
- `data_sram_en = exe_valid && mem_allow_in && (mem_we || res_from_mem)`.
- `data_sram_we = 4'hF` when `exe_valid && mem_allow_in && mem_we`, else 4'h0.
- `data_sram_addr = alu_result`.
- `data_sram_wdata = rkd_value`.
- A load/store never carries a `div_op`.

## Timing
- Reset state: `exe_valid`=0, FSM=IDLE, counter=0. Outputs: `exe_to_mem_valid`=0, `exe_allow_in`=1, `data_sram_en`=0, `data_sram_we`=0. `exe_to_mem_bus` is don't-care while invalid.
- Non-divide latency: 1 cycle. The instruction enters at edge E and is offered to the memory stage in the cycle after E.
- Divide latency: the instruction enters at edge E. IDLE→BUSY at E+1, DONE at E+33, so `exe_to_mem_valid` first rises in cycle E+33.
- While BUSY or in DONE without `mem_allow_in`:
  - `exe_allow_in` = 0.
  - `exe_reg` and the divider result are held stable.
  - Nothing is re-latched.
- Back-to-back divides: the second enters on the DONE handoff edge and starts from IDLE on the next edge. No result bleeds from the first divide into the second.
- SRAM request is combinational and issued only in the cycle the instruction advances. Read data is returned to `mem_stage` on the following cycle.
- Reset assertion mid-divide: FSM returns to IDLE immediately, `exe_valid` is cleared, and no partial result is emitted.

## Test plan
- **ALU**: add `0xFFFFFFFF+1` → `alu_result` 0, `exe_to_mem_valid` one cycle after entry. sra `0x80000000`, shift 4 → `0xF8000000`.
- **Store**: `src1=0x1000`, `src2=4`, add, `mem_we=1`, `rkd=0xDEADBEEF`, `mem_allow_in=1` → en=1, we=F, addr=0x1004, wdata=0xDEADBEEF for exactly one cycle.
- **Signed divide**: div.w -7/2 → quotient 0xFFFFFFFD. mod.w -7/2 → 0xFFFFFFFF. Valid rises exactly 33 cycles after entry; `exe_allow_in` stays low meanwhile.
- **Corner divides**: div.wu 5/0 → 0xFFFFFFFF; mod.wu 5/0 → 5. div.w 0x80000000/0xFFFFFFFF → 0x80000000; mod.w of the same operands → 0.
- **Back-pressure**: hold `mem_allow_in=0` for 5 cycles after DONE → bus and valid stable, no SRAM request. Release → handoff on the next edge and FSM back to IDLE.
- **Reset mid-divide**: pull `reset` low at iteration 10 → valid=0 and allow_in=1 asynchronously. After release, a fresh div.wu 100/7 yields 14.

Source files
------------

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : exe_stage
//  Description : Execute stage of the five-stage in-order pipeline.
//                Computes the one-hot ALU result, runs a 32-iteration
//                radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu,
//                and issues the data-SRAM request for loads and stores.
//                Uses the valid/allow-in handshake on both sides.
//
//  Ports       : clk              - clock, rising edge
//                reset            - asynchronous reset, active low
//                exe_allow_in     - stage can accept a new instruction
//                id_to_exe_valid  - decode stage offers an instruction
//                mem_allow_in     - memory stage can accept
//                exe_to_mem_valid - this stage offers an instruction
//                id_to_exe_bus    - {pc, alu_op[11:0], div_op[3:0], src1,
//                                    src2, rkd_value, mem_we, res_from_mem,
//                                    reg_we, reg_waddr[4:0]}
//                exe_to_mem_bus   - {pc, alu_result, res_from_mem, reg_we,
//                                    reg_waddr[4:0]}
//                data_sram_en/we/addr/wdata - data SRAM request
//
//  Revision    : 1.0 - initial release
// ============================================================================
module exe_stage #(
    parameter int ID_TO_EXE_BUS_WIDTH  = 152,
    parameter int EXE_TO_MEM_BUS_WIDTH = 71
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            exe_allow_in,
    input  logic                            id_to_exe_valid,
    input  logic                            mem_allow_in,
    output logic                            exe_to_mem_valid,
    input  logic [ID_TO_EXE_BUS_WIDTH-1:0]  id_to_exe_bus,
    output logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
    output logic                            data_sram_en,
    output logic [3:0]                      data_sram_we,
    output logic [31:0]                     data_sram_addr,
    output logic [31:0]                     data_sram_wdata
);

    localparam logic [4:0] c_DIV_LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic                           r_exe_valid;
    logic [ID_TO_EXE_BUS_WIDTH-1:0] r_exe_reg;
    logic                           w_exe_ready_go;

    // Decoded fields of the held instruction
    logic [31:0] w_pc;
    logic [11:0] w_alu_op;
    logic [3:0]  w_div_op;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_rkd_value;
    logic        w_mem_we;
    logic        w_res_from_mem;
    logic        w_reg_we;
    logic [4:0]  w_reg_waddr;

    assign w_pc           = r_exe_reg[151:120];
    assign w_alu_op       = r_exe_reg[119:108];
    assign w_div_op       = r_exe_reg[107:104];
    assign w_src1         = r_exe_reg[103:72];
    assign w_src2         = r_exe_reg[71:40];
    assign w_rkd_value    = r_exe_reg[39:8];
    assign w_mem_we       = r_exe_reg[7];
    assign w_res_from_mem = r_exe_reg[6];
    assign w_reg_we       = r_exe_reg[5];
    assign w_reg_waddr    = r_exe_reg[4:0];

    logic w_is_div;
    assign w_is_div = (w_div_op != 4'd0);

    assign exe_allow_in     = !r_exe_valid || (w_exe_ready_go && mem_allow_in);
    assign exe_to_mem_valid = r_exe_valid && w_exe_ready_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exe_valid <= 1'b0;
        end else if (exe_allow_in) begin
            r_exe_valid <= id_to_exe_valid;
        end
    end

    // Payload register carries no reset: it is only meaningful under r_exe_valid.
    always_ff @(posedge clk) begin
        if (exe_allow_in && id_to_exe_valid) begin
            r_exe_reg <= id_to_exe_bus;
        end
    end

    // ------------------------------------------------------------------------
    // ALU (one-hot op select; all-zero op yields zero)
    // ------------------------------------------------------------------------
    logic [4:0]  w_shamt;
    logic [31:0] w_add_res;
    logic [31:0] w_sub_res;
    logic [31:0] w_slt_res;
    logic [31:0] w_sltu_res;
    logic [31:0] w_sll_res;
    logic [31:0] w_srl_res;
    logic [31:0] w_sra_res;
    logic [31:0] w_alu_out;

    assign w_shamt    = w_src2[4:0];
    assign w_add_res  = w_src1 + w_src2;
    assign w_sub_res  = w_src1 - w_src2;
    assign w_slt_res  = {31'd0, ($signed(w_src1) < $signed(w_src2))};
    assign w_sltu_res = {31'd0, (w_src1 < w_src2)};
    assign w_sll_res  = w_src1 << w_shamt;
    assign w_srl_res  = w_src1 >> w_shamt;
    assign w_sra_res  = $unsigned($signed(w_src1) >>> w_shamt);

    assign w_alu_out = ({32{w_alu_op[0]}}  & w_add_res)
                     | ({32{w_alu_op[1]}}  & w_sub_res)
                     | ({32{w_alu_op[2]}}  & w_slt_res)
                     | ({32{w_alu_op[3]}}  & w_sltu_res)
                     | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
                     | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                     | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
                     | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                     | ({32{w_alu_op[8]}}  & w_sll_res)
                     | ({32{w_alu_op[9]}}  & w_srl_res)
                     | ({32{w_alu_op[10]}} & w_sra_res)
                     | ({32{w_alu_op[11]}} & w_src2);

    // ------------------------------------------------------------------------
    // Divider: restoring, one quotient bit per cycle on operand magnitudes
    // ------------------------------------------------------------------------
    div_state_t r_div_state;
    div_state_t w_div_state_nxt;

    logic [4:0]  r_div_cnt;
    logic [31:0] r_rem;        // partial remainder
    logic [31:0] r_quo;        // dividend shifts out the top, quotient in the bottom
    logic [31:0] r_dvsr;       // divisor magnitude
    logic [31:0] r_dvnd_raw;   // original src1, returned as remainder on divide-by-zero
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;

    logic        w_div_start;
    logic        w_is_signed;
    logic        w_src1_neg;
    logic        w_src2_neg;
    logic [31:0] w_dvnd_mag;
    logic [31:0] w_dvsr_mag;

    assign w_div_start = (r_div_state == S_IDLE) && r_exe_valid && w_is_div;
    assign w_is_signed = w_div_op[0] | w_div_op[1];
    assign w_src1_neg  = w_is_signed & w_src1[31];
    assign w_src2_neg  = w_is_signed & w_src2[31];
    assign w_dvnd_mag  = w_src1_neg ? (~w_src1 + 32'd1) : w_src1;
    assign w_dvsr_mag  = w_src2_neg ? (~w_src2 + 32'd1) : w_src2;

    // The invariant rem < divisor keeps rem_shift < 2*divisor, so bit 32 of
    // the 33-bit difference is a clean borrow flag.
    logic [32:0] w_rem_shift;
    logic [32:0] w_rem_diff;
    logic        w_qbit;
    logic [31:0] w_rem_next;

    assign w_rem_shift = {r_rem, r_quo[31]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_dvsr};
    assign w_qbit      = ~w_rem_diff[32];
    assign w_rem_next  = w_qbit ? w_rem_diff[31:0] : w_rem_shift[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_state <= S_IDLE;
        end else begin
            r_div_state <= w_div_state_nxt;
        end
    end

    always_comb begin
        w_div_state_nxt = r_div_state;
        case (r_div_state)
            S_IDLE: begin
                if (w_div_start) begin
                    w_div_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_div_cnt == c_DIV_LAST_ITER) begin
                    w_div_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_exe_ready_go && mem_allow_in) begin
                    w_div_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_div_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt  <= 5'd0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_dvsr     <= 32'd0;
            r_dvnd_raw <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_div_start) begin
            r_div_cnt  <= 5'd0;
            r_rem      <= 32'd0;
            r_quo      <= w_dvnd_mag;
            r_dvsr     <= w_dvsr_mag;
            r_dvnd_raw <= w_src1;
            r_neg_q    <= w_src1_neg ^ w_src2_neg;
            r_neg_r    <= w_src1_neg;
            r_div_zero <= (w_src2 == 32'd0);
        end else if (r_div_state == S_BUSY) begin
            r_rem     <= w_rem_next;
            r_quo     <= {r_quo[30:0], w_qbit};
            r_div_cnt <= r_div_cnt + 5'd1;
        end
    end

    // Sign fix-up. -2^31 / -1 needs no special case: the magnitude quotient
    // is 0x80000000 with a positive sign, remainder 0.
    logic [31:0] w_quo_final;
    logic [31:0] w_rem_final;
    logic [31:0] w_div_result;

    always_comb begin
        w_quo_final = r_neg_q ? (~r_quo + 32'd1) : r_quo;
        w_rem_final = r_neg_r ? (~r_rem + 32'd1) : r_rem;
        if (r_div_zero) begin
            w_quo_final = 32'hFFFF_FFFF;
            w_rem_final = r_dvnd_raw;
        end
    end

    assign w_div_result   = (w_div_op[0] | w_div_op[2]) ? w_quo_final : w_rem_final;
    assign w_exe_ready_go = w_is_div ? (r_div_state == S_DONE) : 1'b1;

    // ------------------------------------------------------------------------
    // Result, memory-stage bus and SRAM request
    // ------------------------------------------------------------------------
    logic [31:0] w_alu_result;
    assign w_alu_result = w_is_div ? w_div_result : w_alu_out;

    assign exe_to_mem_bus = {w_pc, w_alu_result, w_res_from_mem, w_reg_we, w_reg_waddr};

    assign data_sram_en    = r_exe_valid && mem_allow_in && (w_mem_we || w_res_from_mem);
    assign data_sram_we    = (r_exe_valid && mem_allow_in && w_mem_we) ? 4'hF : 4'h0;
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rkd_value;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_stage
//  Description : Directed self-checking bench for exe_stage: ALU ops, store
//                and load requests, signed/unsigned divides with corner
//                cases, back-pressure, back-to-back divides, reset mid-divide.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic         exe_allow_in;
    logic         id_to_exe_valid;
    logic         mem_allow_in;
    logic         exe_to_mem_valid;
    logic [151:0] id_to_exe_bus;
    logic [70:0]  exe_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] c_OP_ADD  = 12'h001;
    localparam logic [11:0] c_OP_SUB  = 12'h002;
    localparam logic [11:0] c_OP_SLT  = 12'h004;
    localparam logic [11:0] c_OP_SLTU = 12'h008;
    localparam logic [11:0] c_OP_SRA  = 12'h400;
    localparam logic [11:0] c_OP_LUI  = 12'h800;
    localparam logic [3:0]  c_DIV_W   = 4'b0001;
    localparam logic [3:0]  c_MOD_W   = 4'b0010;
    localparam logic [3:0]  c_DIV_WU  = 4'b0100;
    localparam logic [3:0]  c_MOD_WU  = 4'b1000;

    exe_stage dut (
        .clk              (clk),
        .reset            (reset),
        .exe_allow_in     (exe_allow_in),
        .id_to_exe_valid  (id_to_exe_valid),
        .mem_allow_in     (mem_allow_in),
        .exe_to_mem_valid (exe_to_mem_valid),
        .id_to_exe_bus    (id_to_exe_bus),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [151:0] mk(input logic [31:0] pc, input logic [11:0] aop,
                                        input logic [3:0] dop, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] rkd,
                                        input logic mwe, input logic rfm, input logic rwe,
                                        input logic [4:0] wa);
        return {pc, aop, dop, s1, s2, rkd, mwe, rfm, rwe, wa};
    endfunction

    function automatic logic [70:0] mbus(input logic [31:0] pc, input logic [31:0] res,
                                         input logic rfm, input logic rwe, input logic [4:0] wa);
        return {pc, res, rfm, rwe, wa};
    endfunction

    // Offer one instruction; returns just after the entry edge.
    task automatic issue(input logic [151:0] b);
        id_to_exe_bus   = b;
        id_to_exe_valid = 1'b1;
        tick();
        id_to_exe_valid = 1'b0;
    endtask

    // Called right after the entry edge E; returns in cycle E+33.
    task automatic wait_div(input string tag);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 33; k++) begin
            if (exe_to_mem_valid !== 1'b0 || exe_allow_in !== 1'b0) bad = 1'b1;
            tick();
        end
        check({tag, "_stall"}, {70'd0, bad}, 71'd0);
        check({tag, "_valid"}, {70'd0, exe_to_mem_valid}, 71'd1);
    endtask

    task automatic do_div(input string tag, input logic [3:0] dop, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [31:0] exp);
        issue(mk(32'h0000_0100, 12'h000, dop, s1, s2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3));
        wait_div(tag);
        check({tag, "_bus"}, exe_to_mem_bus, mbus(32'h0000_0100, exp, 1'b0, 1'b1, 5'd3));
        tick();
        check({tag, "_handoff"}, {69'd0, exe_to_mem_valid, exe_allow_in}, {69'd0, 1'b0, 1'b1});
    endtask

    task automatic do_alu(input string tag, input logic [11:0] aop, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [31:0] exp);
        issue(mk(32'h0000_0040, aop, 4'd0, s1, s2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7));
        check({tag, "_valid"}, {70'd0, exe_to_mem_valid}, 71'd1);
        check({tag, "_bus"}, exe_to_mem_bus, mbus(32'h0000_0040, exp, 1'b0, 1'b1, 5'd7));
    endtask

    initial begin
        logic        bad;
        logic [70:0] held;

        reset           = 1'b0;
        id_to_exe_valid = 1'b0;
        mem_allow_in    = 1'b1;
        id_to_exe_bus   = '0;
        tick();
        tick();

        // Reset state
        check("rst_valid", {70'd0, exe_to_mem_valid}, 71'd0);
        check("rst_allow", {70'd0, exe_allow_in}, 71'd1);
        check("rst_en",    {70'd0, data_sram_en}, 71'd0);
        check("rst_we",    {67'd0, data_sram_we}, 71'd0);
        reset = 1'b1;
        tick();

        // ALU
        do_alu("add_wrap", c_OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0);
        do_alu("sra",      c_OP_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000);
        do_alu("sub",      c_OP_SUB, 32'h3, 32'h5, 32'hFFFF_FFFE);
        do_alu("slt",      c_OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
        do_alu("sltu",     c_OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
        do_alu("lui",      c_OP_LUI, 32'h0, 32'h1234_5000, 32'h1234_5000);
        do_alu("noop",     12'h000, 32'h5, 32'h6, 32'h0);
        tick();
        check("alu_drain", {70'd0, exe_to_mem_valid}, 71'd0);

        // Store: request for exactly one cycle
        issue(mk(32'h0000_0200, c_OP_ADD, 4'd0, 32'h1000, 32'h4, 32'hDEAD_BEEF,
                 1'b1, 1'b0, 1'b0, 5'd0));
        check("st_en",    {70'd0, data_sram_en}, 71'd1);
        check("st_we",    {67'd0, data_sram_we}, 71'hF);
        check("st_addr",  {39'd0, data_sram_addr}, {39'd0, 32'h0000_1004});
        check("st_wdata", {39'd0, data_sram_wdata}, {39'd0, 32'hDEAD_BEEF});
        tick();
        check("st_en_off", {70'd0, data_sram_en}, 71'd0);
        check("st_we_off", {67'd0, data_sram_we}, 71'd0);

        // Load: request gated by mem_allow_in
        mem_allow_in = 1'b0;
        issue(mk(32'h0000_0300, c_OP_ADD, 4'd0, 32'h2000, 32'h8, 32'd0,
                 1'b0, 1'b1, 1'b1, 5'd9));
        check("ld_en_blocked", {70'd0, data_sram_en}, 71'd0);
        mem_allow_in = 1'b1;
        #1;
        check("ld_en",   {70'd0, data_sram_en}, 71'd1);
        check("ld_we",   {67'd0, data_sram_we}, 71'd0);
        check("ld_addr", {39'd0, data_sram_addr}, {39'd0, 32'h0000_2008});
        tick();

        // Divides
        do_div("divw",     c_DIV_W,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
        do_div("modw",     c_MOD_W,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
        do_div("divw_pn",  c_DIV_W,  32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        do_div("divwu_z",  c_DIV_WU, 32'h5, 32'h0, 32'hFFFF_FFFF);
        do_div("modwu_z",  c_MOD_WU, 32'h5, 32'h0, 32'h5);
        do_div("divw_ovf", c_DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_div("modw_ovf", c_MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Back-pressure at DONE, then a back-to-back divide
        issue(mk(32'h0000_0400, 12'h000, c_MOD_WU, 32'd100, 32'd7, 32'd0,
                 1'b0, 1'b0, 1'b1, 5'd4));
        wait_div("bp_mod");
        held = mbus(32'h0000_0400, 32'd2, 1'b0, 1'b1, 5'd4);
        check("bp_mod_bus", exe_to_mem_bus, held);
        mem_allow_in = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (exe_to_mem_valid !== 1'b1 || exe_to_mem_bus !== held ||
                data_sram_en !== 1'b0 || exe_allow_in !== 1'b0) bad = 1'b1;
        end
        check("bp_hold", {70'd0, bad}, 71'd0);
        id_to_exe_bus   = mk(32'h0000_0500, 12'h000, c_DIV_WU, 32'd100, 32'd7, 32'd0,
                             1'b0, 1'b0, 1'b1, 5'd5);
        id_to_exe_valid = 1'b1;
        mem_allow_in    = 1'b1;
        #1;
        check("bp_release_allow", {70'd0, exe_allow_in}, 71'd1);
        tick();
        id_to_exe_valid = 1'b0;
        wait_div("b2b_div");
        check("b2b_div_bus", exe_to_mem_bus, mbus(32'h0000_0500, 32'd14, 1'b0, 1'b1, 5'd5));
        tick();

        // Reset during iteration 10
        issue(mk(32'h0000_0600, 12'h000, c_DIV_W, 32'd1000, 32'd3, 32'd0,
                 1'b0, 1'b0, 1'b1, 5'd6));
        for (int k = 0; k < 11; k++) tick();
        reset = 1'b0;
        #1;
        check("mrst_valid", {70'd0, exe_to_mem_valid}, 71'd0);
        check("mrst_allow", {70'd0, exe_allow_in}, 71'd1);
        tick();
        reset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (exe_to_mem_valid !== 1'b0) bad = 1'b1;
        end
        check("mrst_no_partial", {70'd0, bad}, 71'd0);
        do_div("mrst_divwu", c_DIV_WU, 32'd100, 32'd7, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
